// File: rtl/mips_trace_monitor.sv
// Execution-trace monitor for the 16-bit MIPS core: records every PC change into a
// circular buffer until halt or timeout, then replays the trace oldest-first on request.
module mips_trace_monitor #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 4,
   parameter int TIMEOUT     = 50,
   localparam int PTR_W      = $clog2(DEPTH),
   localparam int CNT_W      = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] result_in,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_pc,
   output logic [DATA_W-1:0] rd_result,
   output logic              rd_last,
   output logic [1:0]        state,
   output logic              halted,
   output logic              timed_out,
   output logic              wrapped,
   output logic [PTR_W:0]    entry_count,
   output logic [CNT_W-1:0]  cycle_count
);
   localparam int SW = $clog2(HALT_CYCLES + 1);
   localparam logic [PTR_W:0]   FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   ONE  = (PTR_W + 1)'(1);
   localparam logic [CNT_W-1:0] CMAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;
   state_t state_q, state_next;

   logic [DATA_W-1:0] mem_pc  [DEPTH];
   logic [DATA_W-1:0] mem_res [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    unread;
   logic [SW-1:0]     stable;
   logic [DATA_W-1:0] last_pc;
   logic              have_last;
   logic              clear, capture_en, pop;
   logic              write, halt_hit, timeout_hit;

   assign state       = state_q;
   assign write       = !have_last || (pc_in != last_pc);
   assign halt_hit    = capture_en && !write && ((int'(stable) + 1) >= HALT_CYCLES);
   assign timeout_hit = capture_en && ((int'(cycle_count) + 1) >= TIMEOUT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_next;
   end

   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE:    if (start) state_next = CAPTURE;
         CAPTURE: if (halt_hit || timeout_hit) state_next = DONE;
         DONE: begin
            if (start)                       state_next = CAPTURE;
            else if (pop && (unread == ONE)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // start in DONE abandons unread entries, so it takes priority over a pop
   always_comb begin
      clear      = 1'b0;
      capture_en = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE:    clear = start;
         CAPTURE: capture_en = 1'b1;
         DONE: begin
            clear = start;
            pop   = !start && rd_req && (unread != '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (capture_en && write) begin
         mem_pc[wr_ptr]  <= pc_in;
         mem_res[wr_ptr] <= result_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         unread      <= '0;
         stable      <= '0;
         last_pc     <= '0;
         have_last   <= 1'b0;
         entry_count <= '0;
         cycle_count <= '0;
         halted      <= 1'b0;
         timed_out   <= 1'b0;
         wrapped     <= 1'b0;
      end else if (clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         unread      <= '0;
         stable      <= '0;
         have_last   <= 1'b0;
         entry_count <= '0;
         cycle_count <= '0;
         halted      <= 1'b0;
         timed_out   <= 1'b0;
         wrapped     <= 1'b0;
      end else if (capture_en) begin
         if (cycle_count != CMAX) cycle_count <= cycle_count + 1'b1;
         if (write) begin
            wr_ptr    <= wr_ptr + 1'b1;
            last_pc   <= pc_in;
            have_last <= 1'b1;
            stable    <= '0;
            // a full buffer drops its oldest entry; fullness lives in entry_count
            if (entry_count == FULL) begin
               rd_ptr  <= rd_ptr + 1'b1;
               wrapped <= 1'b1;
            end else begin
               entry_count <= entry_count + 1'b1;
               unread      <= unread + 1'b1;
            end
         end else begin
            stable <= stable + 1'b1;
         end
         if (halt_hit)    halted    <= 1'b1;
         if (timeout_hit) timed_out <= 1'b1;
      end else if (pop) begin
         rd_ptr <= rd_ptr + 1'b1;
         unread <= unread - 1'b1;
      end
   end

   // read port stage: one-cycle latency, all fields zero when not valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_pc     <= '0;
         rd_result <= '0;
      end else if (pop) begin
         rd_valid  <= 1'b1;
         rd_last   <= (unread == ONE);
         rd_pc     <= mem_pc[rd_ptr];
         rd_result <= mem_res[rd_ptr];
      end else begin
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_pc     <= '0;
         rd_result <= '0;
      end
   end
endmodule

// File: tb/tb_mips_trace_monitor.sv
// Bench for mips_trace_monitor: table of capture scenarios plus a trace scoreboard,
// followed by hand-written sequences for ignored inputs and reset during readout.
module tb_mips_trace_monitor;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int HALT  = 4;
   localparam int TMO   = 20;

   logic          clk = 1'b0;
   logic          reset, start, rd_req;
   logic [DW-1:0] pc_in, result_in;
   logic          rd_valid, rd_last, halted, timed_out, wrapped;
   logic [DW-1:0] rd_pc, rd_result;
   logic [1:0]    state;
   logic [2:0]    entry_count;
   logic [4:0]    cycle_count;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] sb_pc[$];
   logic [DW-1:0] sb_res[$];
   logic          sb_have;
   logic [DW-1:0] sb_last;

   typedef struct {
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      int            n;
      logic          exp_halt;
      logic          exp_to;
      logic          exp_wrap;
      int            exp_entries;
      int            exp_cycles;
   } scen_t;
   scen_t tbl[6];

   mips_trace_monitor #(.DATA_W(DW), .DEPTH(DEPTH), .HALT_CYCLES(HALT), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .result_in(result_in),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_result(rd_result),
      .rd_last(rd_last), .state(state), .halted(halted), .timed_out(timed_out),
      .wrapped(wrapped), .entry_count(entry_count), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [DW-1:0] res_of(input logic [DW-1:0] pc);
      return {pc[7:0], pc[15:8]} ^ 16'h5A5A;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic begin_capture();
      start = 1'b1;
      sb_pc.delete();
      sb_res.delete();
      sb_have = 1'b0;
      tick();
      start = 1'b0;
   endtask

   // drive one sample; the scoreboard keeps the newest DEPTH distinct-PC writes
   task automatic drive_sample(input logic [DW-1:0] pc);
      pc_in     = pc;
      result_in = res_of(pc);
      if (!sb_have || pc != sb_last) begin
         sb_pc.push_back(pc);
         sb_res.push_back(res_of(pc));
         if (sb_pc.size() > DEPTH) begin
            void'(sb_pc.pop_front());
            void'(sb_res.pop_front());
         end
         sb_have = 1'b1;
         sb_last = pc;
      end
      tick();
   endtask

   task automatic read_entries(input int n);
      logic [DW-1:0] ep, er;
      logic          el;
      rd_req = 1'b1;
      for (int k = 0; k < n; k++) begin
         tick();
         ep = (sb_pc.size() > 0) ? sb_pc.pop_front() : '0;
         er = (sb_res.size() > 0) ? sb_res.pop_front() : '0;
         el = (sb_pc.size() == 0);
         check("rd_valid", rd_valid, 1);
         check("rd_pc", rd_pc, ep);
         check("rd_result", rd_result, er);
         check("rd_last", rd_last, el);
      end
   endtask

   initial begin
      tbl[0] = '{16'h0000, 16'h0002, 4,  1'b1, 1'b0, 1'b0, 4, 8};
      tbl[1] = '{16'h0000, 16'h0002, 8,  1'b1, 1'b0, 1'b1, 4, 12};
      tbl[2] = '{16'h0100, 16'h0001, 30, 1'b0, 1'b1, 1'b1, 4, 20};
      tbl[3] = '{16'h0200, 16'h0001, 16, 1'b1, 1'b1, 1'b1, 4, 20};
      tbl[4] = '{16'h0300, 16'h0000, 1,  1'b1, 1'b0, 1'b0, 1, 5};
      tbl[5] = '{16'h0400, 16'h0004, 3,  1'b1, 1'b0, 1'b0, 3, 7};

      reset = 1'b1; start = 1'b0; rd_req = 1'b0; pc_in = '0; result_in = '0;
      sb_have = 1'b0; sb_last = '0;
      #1;
      check("reset_state", state, 0);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_entry_count", entry_count, 0);
      check("reset_cycle_count", cycle_count, 0);
      check("reset_flags", {halted, timed_out, wrapped}, 0);
      tick(); tick();
      reset = 1'b0;
      tick();
      check("idle_state", state, 0);

      foreach (tbl[i]) begin
         begin_capture();
         check("cap_state", state, 1);
         for (int c = 0; c < 40 && state == 2'd1; c++)
            drive_sample((c < tbl[i].n) ? 16'(tbl[i].base + c * tbl[i].step)
                                        : 16'(tbl[i].base + (tbl[i].n - 1) * tbl[i].step));
         check("done_state", state, 2);
         check("halted", halted, tbl[i].exp_halt);
         check("timed_out", timed_out, tbl[i].exp_to);
         check("wrapped", wrapped, tbl[i].exp_wrap);
         check("entry_count", entry_count, tbl[i].exp_entries);
         check("cycle_count", cycle_count, tbl[i].exp_cycles);
         read_entries(tbl[i].exp_entries);
         tick();
         check("rd_after_last", rd_valid, 0);
         check("idle_after_read", state, 0);
         check("flags_hold", halted, tbl[i].exp_halt);
         rd_req = 1'b0;
      end

      // rd_req and start are ignored while capturing
      begin_capture();
      rd_req = 1'b1;
      drive_sample(16'h0010);
      check("rdreq_in_capture", rd_valid, 0);
      drive_sample(16'h0012);
      check("rdreq_in_capture", rd_valid, 0);
      rd_req = 1'b0;
      start = 1'b1;
      drive_sample(16'h0014);
      start = 1'b0;
      check("start_in_capture_cycles", cycle_count, 3);
      check("start_in_capture_state", state, 1);
      drive_sample(16'h0016);
      repeat (HALT) drive_sample(16'h0016);
      check("seq_done", state, 2);
      check("seq_halted", halted, 1);
      check("seq_entries", entry_count, 4);
      check("seq_cycles", cycle_count, 8);
      read_entries(2);
      rd_req = 1'b0;

      // start in DONE after two of four reads restarts with an empty buffer
      begin_capture();
      check("restart_state", state, 1);
      check("restart_entries", entry_count, 0);
      check("restart_cycles", cycle_count, 0);
      check("restart_rd_valid", rd_valid, 0);

      drive_sample(16'h0040);
      drive_sample(16'h0042);
      repeat (HALT) drive_sample(16'h0042);
      check("rst_seq_done", state, 2);
      check("rst_seq_entries", entry_count, 2);
      read_entries(1);

      // asynchronous reset in the middle of readout
      reset = 1'b1;
      #1;
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_pc", rd_pc, 0);
      check("rst_rd_result", rd_result, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_state", state, 0);
      check("rst_counts", {entry_count, cycle_count}, 0);
      check("rst_flags", {halted, timed_out, wrapped}, 0);
      #1;
      reset = 1'b0;
      tick();
      check("post_rst_state", state, 0);
      check("post_rst_rd_valid", rd_valid, 0);
      tick();
      check("post_rst_rd_valid2", rd_valid, 0);
      rd_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
